// File: rtl/clock_div_pkg.sv
// clock_div_pkg: shared FSM state type and default widths for divider-side logic.
package clock_div_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  localparam int DIV_W = 8;
  localparam int CNT_W = 9;
  localparam int TIMEOUT_CYC = 1024;
endpackage

// File: rtl/clock_edge_detect.sv
// clock_edge_detect: samples clock_in into clk and flags its rising/falling edges.
// Define INPUT_SYNC_EN to insert a 2-flop synchronizer ahead of the sample register.
module clock_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic clock_in,
  output logic s,
  output logic rise,
  output logic fall
);
  logic p;
`ifdef INPUT_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '0;
      s <= 1'b0;
      p <= 1'b0;
    end else begin
      sync <= {sync[0], clock_in};
      s <= sync[1];
      p <= s;
    end
`else
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s <= 1'b0;
      p <= 1'b0;
    end else begin
      s <= clock_in;
      p <= s;
    end
`endif
  assign rise = s & ~p;
  assign fall = ~s & p;
endmodule

// File: rtl/clock_ratio_meter.sv
// clock_ratio_meter: measures high/low/period of a divided clock in clk cycles, with lock and stall status.
// Define INPUT_SYNC_EN when clock_in is asynchronous to clk (adds 2 cycles of latency).
module clock_ratio_meter #(
  parameter int CNT_W = clock_div_pkg::CNT_W,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT_CYC = clock_div_pkg::TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clock_in,
  output logic [CNT_W-1:0] high_out,
  output logic [CNT_W-1:0] low_out,
  output logic [CNT_W:0]   period_out,
  output logic             ovf_out,
  output logic             meas_valid,
  output logic             locked,
  output logic             stalled
);
  import clock_div_pkg::*;
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  state_t state, state_d;
  logic [CNT_W-1:0] hi_cnt, lo_cnt;
  logic [CNT_W:0] period_d;
  logic [IW-1:0] idle_cnt;
  logic [MW-1:0] match_cnt, match_d;
  logic ovf, s, rise, fall, any_edge, timeout, publish;
  clock_edge_detect u_edge (
    .clk(clk),
    .rst(rst),
    .clock_in(clock_in),
    .s(s),
    .rise(rise),
    .fall(fall)
  );
  assign any_edge = rise | fall;
  assign timeout = !any_edge && idle_cnt == IW'(TIMEOUT_CYC - 1);
  assign publish = state == LOW && rise;
  assign period_d = {1'b0, hi_cnt} + {1'b0, lo_cnt};
  always_comb begin
    state_d = timeout ? IDLE : rise ? HIGH : (fall && state == HIGH) ? LOW : state;
    match_d = (ovf || match_cnt == '0 || period_d != period_out) ? MW'(1) :
              match_cnt == MW'(LOCK_CNT) ? match_cnt : match_cnt + MW'(1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      hi_cnt <= '0;
      lo_cnt <= '0;
      ovf <= 1'b0;
      idle_cnt <= '0;
      match_cnt <= '0;
      high_out <= '0;
      low_out <= '0;
      period_out <= '0;
      ovf_out <= 1'b0;
      meas_valid <= 1'b0;
      locked <= 1'b0;
      stalled <= 1'b0;
    end else begin
      state <= state_d;
      meas_valid <= publish;
      // idle_cnt parks at TIMEOUT_CYC so a stall fires only once per quiet spell
      idle_cnt <= any_edge ? '0 : idle_cnt == IW'(TIMEOUT_CYC) ? idle_cnt : idle_cnt + IW'(1);
      if (timeout) begin
        stalled <= 1'b1;
        locked <= 1'b0;
        match_cnt <= '0;
      end else if (rise) stalled <= 1'b0;
      if (publish) begin
        high_out <= hi_cnt;
        low_out <= lo_cnt;
        period_out <= period_d;
        ovf_out <= ovf;
        match_cnt <= match_d;
        locked <= !ovf && match_d == MW'(LOCK_CNT);
      end
      if (state_d == IDLE) begin
        hi_cnt <= '0;
        lo_cnt <= '0;
        ovf <= 1'b0;
      end else if (rise) begin
        hi_cnt <= CNT_W'(1);
        ovf <= 1'b0;
      end else if (state == HIGH && fall) lo_cnt <= CNT_W'(1);
      else if (state == HIGH && s) begin
        if (hi_cnt == MAX) ovf <= 1'b1;
        else hi_cnt <= hi_cnt + CNT_W'(1);
      end else if (state == LOW && !s) begin
        if (lo_cnt == MAX) ovf <= 1'b1;
        else lo_cnt <= lo_cnt + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_clock_ratio_meter.sv
// tb_clock_ratio_meter: directed + random stimulus checked every cycle against an edge-time reference model.
module tb_clock_ratio_meter;
  localparam int CNT_W = 9;
  localparam int T = 1024;
  localparam int MAXV = (1 << CNT_W) - 1;
`ifdef INPUT_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0, rst = 1'b1, clock_in = 1'b0;
  logic [CNT_W-1:0] high_out, low_out;
  logic [CNT_W:0] period_out;
  logic ovf_out, meas_valid, locked, stalled;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {int hi; int lo; int per; int ovf; int mv; int lk; int st;} snap_t;
  snap_t q[$];
  snap_t cur;
  int prev, last_change, t_rise, t_fall;
  bit have_rise, have_fall;
  int hist_p[$];
  bit hist_o[$];
  always #5 clk = ~clk;
  clock_ratio_meter dut (
    .clk(clk),
    .rst(rst),
    .clock_in(clock_in),
    .high_out(high_out),
    .low_out(low_out),
    .period_out(period_out),
    .ovf_out(ovf_out),
    .meas_valid(meas_valid),
    .locked(locked),
    .stalled(stalled)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask
  // locked: the last LOCK_CNT periods agree and none but the oldest overflowed
  function automatic bit lock_ok();
    int n = hist_p.size();
    if (n < 4) return 1'b0;
    for (int i = n - 4; i < n; i++) begin
      if (hist_p[i] != hist_p[n-1]) return 1'b0;
      if (i > n - 4 && hist_o[i]) return 1'b0;
    end
    return 1'b1;
  endfunction
  task automatic model(int v);
    bit r = v != 0 && prev == 0;
    bit f = v == 0 && prev != 0;
    cur.mv = 0;
    if (r || f) last_change = cyc;
    else if (cyc - last_change == T) begin
      cur.st = 1;
      cur.lk = 0;
      have_rise = 0;
      hist_p.delete();
      hist_o.delete();
    end
    if (r) begin
      if (have_rise && have_fall) begin
        int h, l;
        h = t_fall - t_rise;
        l = cyc - t_fall;
        cur.hi = h > MAXV ? MAXV : h;
        cur.lo = l > MAXV ? MAXV : l;
        cur.per = cur.hi + cur.lo;
        cur.ovf = (h > MAXV || l > MAXV) ? 1 : 0;
        cur.mv = 1;
        hist_p.push_back(cur.per);
        hist_o.push_back(cur.ovf != 0);
        cur.lk = lock_ok() ? 1 : 0;
      end
      cur.st = 0;
      have_rise = 1;
      have_fall = 0;
      t_rise = cyc;
    end
    if (f && have_rise) begin
      have_fall = 1;
      t_fall = cyc;
    end
    prev = v;
    q.push_back(cur);
  endtask
  task automatic step(int v);
    snap_t e;
    @(negedge clk);
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("high_out", high_out, e.hi);
      check("low_out", low_out, e.lo);
      check("period_out", period_out, e.per);
      check("ovf_out", ovf_out, e.ovf);
      check("meas_valid", meas_valid, e.mv);
      check("locked", locked, e.lk);
      check("stalled", stalled, e.st);
    end
    clock_in = v[0];
    model(v);
  endtask
  task automatic drive(int h, int l, int n);
    repeat (n) begin
      repeat (h) step(1);
      repeat (l) step(0);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    clock_in = 1'b0;
    #1;
    check("rst_high", high_out, 0);
    check("rst_low", low_out, 0);
    check("rst_period", period_out, 0);
    check("rst_ovf", ovf_out, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_stalled", stalled, 0);
    repeat (2) begin
      @(negedge clk);
      cyc++;
    end
    rst = 1'b0;
    prev = 0;
    last_change = cyc - LAT;
    have_rise = 0;
    have_fall = 0;
    hist_p.delete();
    hist_o.delete();
    cur = '{default: 0};
    q.delete();
    repeat (LAT) q.push_back(cur);
  endtask
  initial begin
    do_reset();
    drive(3, 3, 6);
    check("t1_high", high_out, 3);
    check("t1_period", period_out, 6);
    check("t1_locked", locked, 1);
    drive(2, 5, 5);
    check("t2_high", high_out, 2);
    check("t2_low", low_out, 5);
    check("t2_period", period_out, 7);
    check("t2_ovf", ovf_out, 0);
    drive(3, 3, 5);
    drive(4, 4, 5);
    check("t3_period", period_out, 8);
    check("t3_locked", locked, 1);
    drive(3, 3, 5);
    repeat (1100) step(0);
    check("t4_stalled", stalled, 1);
    check("t4_locked", locked, 0);
    check("t4_held", period_out, 6);
    drive(3, 3, 3);
    check("t4_unstalled", stalled, 0);
    drive(5, 2, 5);
    repeat (5) step(1);
    step(0);
    do_reset();
    drive(3, 3, 1);
    drive(520, 4, 3);
    check("t6_high", high_out, MAXV);
    check("t6_ovf", ovf_out, 1);
    check("t6_locked", locked, 0);
    drive(1, 1, 6);
    check("min_period", period_out, 2);
    check("min_locked", locked, 1);
    repeat (25) drive($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 6));
    repeat (LAT + 1) step(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clock_ratio_meter.md
Name: clock_ratio_meter

Overview:
Receive-side checker for the clock divider. It samples a divided clock in the fast clk domain and measures its high time, low time and period in clk cycles, which recovers the divide ratio. It reports lock when consecutive periods match, and flags a stalled input. It sits next to the divider in bring-up and self-test logic and reports the achieved ratio back to control/status registers.

Parameters:
CNT_W, 9, width of high/low counters; maximum measurable phase is 2^CNT_W-1 cycles.
LOCK_CNT, 4, number of consecutive identical periods required to assert locked.
TIMEOUT_CYC, 1024, clk cycles without an input edge before stalled is asserted; must exceed 2^CNT_W.

Ports:
clk  input  1  fast reference clock; all logic is on its rising edge.
rst  input  1  reset, asynchronous, active-high.
clock_in  input  1  divided clock under measurement.
high_out  output  CNT_W  high-phase length of the last complete period, in clk cycles.
low_out  output  CNT_W  low-phase length of the last complete period.
period_out  output  CNT_W+1  high_out+low_out, zero-extended; equals the divide ratio.
ovf_out  output  1  high or low counter saturated during the last published period.
meas_valid  output  1  one-cycle pulse when high/low/period/ovf update.
locked  output  1  LOCK_CNT consecutive identical periods observed.
stalled  output  1  no edge on clock_in for TIMEOUT_CYC cycles.

Behaviour:
- Reset: every output and all internal counters are 0. FSM goes to IDLE. Edge-detect history is 0.
- Sampled signal s: clock_in registered once. p is s delayed one cycle. rise = s & ~p; fall = ~s & p.
- IDLE: counters held at 0. On rise: hi_cnt<=1 and go to HIGH. Partial periods are never published.
- HIGH: each cycle with s=1, hi_cnt increments and saturates at 2^CNT_W-1, setting a sticky ovf. On fall: lo_cnt<=1 and go to LOW.
- LOW: each cycle with s=0, lo_cnt increments with the same saturation rule. On rise, in the same cycle:
  - publish high_out<=hi_cnt, low_out<=lo_cnt, period_out<=hi_cnt+lo_cnt and ovf_out<=sticky ovf;
  - pulse meas_valid;
  - set hi_cnt<=1, clear sticky ovf, go to HIGH.
- The counting rule makes a clock_in with H high and L low clk cycles publish exactly H and L.
- Publish timing: meas_valid appears 2 clk cycles after the clock_in rising edge reaches the input register (1 sample + 1 output register).
- Lock (evaluated on each meas_valid):
  - First measurement after IDLE: match_cnt=1.
  - Period equal to the previous published period: match_cnt increments, saturating at LOCK_CNT.
  - Any mismatch, or ovf: match_cnt=1 and locked<=0 in the same cycle as meas_valid.
  - locked<=1 when match_cnt reaches LOCK_CNT.
- Timeout: idle_cnt clears on any rise or fall and otherwise increments. At TIMEOUT_CYC:
  - stalled<=1, locked<=0, match_cnt<=0, FSM goes to IDLE;
  - the published values are held.
- stalled clears on the next rise. Measurement then restarts from IDLE semantics, so the first meas_valid comes one full period later.
- Reset asserted mid-measurement: everything clears immediately. No meas_valid is generated from the interrupted period.
- Edge and timeout in the same cycle: the edge wins and idle_cnt clears.
- Minimum measurable input: H=L=1 (clk/2), giving period_out=2.

Optional Feature:
INPUT_SYNC_EN: when defined, clock_in passes through a 2-flop synchronizer before the sample register, for an asynchronous or foreign-domain clock_in. All reported values are unchanged; meas_valid latency grows by 2 cycles. When not defined, clock_in is treated as synchronous to clk and only the single sample register is used.

Decomposition:
- Shared package clock_div_pkg holds:
  - the FSM state enum (IDLE, HIGH, LOW), 2 bits;
  - default widths (DIV_W=8, CNT_W=9);
  - the TIMEOUT_CYC default.
- One natural sub-module: clock_edge_detect, containing the optional synchronizer, sample register and rise/fall outputs. It is reused by other divider-side checkers.

Test Plan:
1. clock_in toggles every 3 clk (H=3, L=3) -> first meas_valid after the second rise with high_out=3, low_out=3, period_out=6; locked=1 on the 4th meas_valid.
2. Asymmetric input, H=2, L=5 -> high_out=2, low_out=5, period_out=7, ovf_out=0.
3. Period 6 held until locked, then switched to H=4, L=4 -> locked drops on the first period_out=8 pulse and reasserts on the 4th consecutive 8.
4. clock_in held low 1100 cycles after lock -> stalled=1 exactly 1024 cycles after the last edge, locked=0, outputs held; next rise clears stalled, next meas_valid one full period later.
5. rst asserted during LOW after lock -> all outputs 0 immediately; after release, no meas_valid until one complete rise-to-rise period has been seen.
6. H=520, L=4 with CNT_W=9 -> high_out=511, ovf_out=1, locked stays 0; with INPUT_SYNC_EN defined, case 1 gives identical values with meas_valid 2 cycles later.
